latch4_write_arbiter: RTL and testbench
=======================================

// Module: latch4_write_arbiter
// PURPOSE
//  Shares one 4-bit gated D-latch register (Data/Enable/Reset/Clock-gate ports) between NUM_REQ writers.
//  Round-robin arbitration, then a fixed SETUP->STROBE->HOLD sequence so data is stable around the gate pulse.
//  Also services a clear command via the latch's Reset input. Sits between bus-side requesters and the latch.
// PARAMETERS
//  NUM_REQ  4  number of write requesters (2..8)
// PORTS
//  Clock        in   1          system clock; all state updates on rising edge
//  Reset        in   1          synchronous, active-high reset
//  Req          in   NUM_REQ    per-requester write request, level, held until Ack
//  ReqData      in   4*NUM_REQ  write data; requester i uses bits [4*i+3:4*i]
//  Ack          out  NUM_REQ    one-hot, one-cycle write-complete pulse
//  ClearReq     in   1          request to clear the latch to 4'b0000
//  ClearAck     out  1          one-cycle clear-complete pulse
//  LatchData    out  4          to latch Data
//  LatchEnable  out  1          to latch Enable (low forces latch to 0)
//  LatchReset   out  1          to latch Reset
//  LatchGate    out  1          to latch Clock (transparent while high)
//  Busy         out  1          high in every state except IDLE
//  GrantId      out  $clog2(NUM_REQ)  index of requester being served (valid while Busy and not CLEAR)
//  LatchQ       in   4          latch Q readback (present only with LATCH4_READBACK_EN)
//  WriteErr     out  1          readback mismatch pulse (tied 0 without LATCH4_READBACK_EN)
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, RR pointer -> requester 0 highest priority, Ack=0, ClearAck=0,
//    LatchData=0, LatchEnable=0 (latch cleared), LatchReset=0, LatchGate=0, Busy=0, GrantId=0, WriteErr=0.
//  - First cycle after Reset released: LatchEnable=1 and stays 1 until next Reset.
//  - States: IDLE, CLEAR, SETUP, STROBE, HOLD.
//  - IDLE: ClearReq has priority -> CLEAR; else any Req -> SETUP with winner latched into GrantId; else stay.
//  - CLEAR (1 cycle): LatchReset=1, ClearAck=1 -> IDLE.
//  - SETUP (1 cycle): LatchData=ReqData[GrantId], LatchGate=0 -> STROBE.
//  - STROBE (1 cycle): LatchGate=1, LatchData held -> HOLD.
//  - HOLD (1 cycle): LatchGate=0, LatchData held, Ack[GrantId]=1 -> IDLE.
//  - Latency: Req sampled in IDLE at edge t -> SETUP t+1, STROBE t+2, Ack in HOLD t+3; 4 cycles min per write.
//  - Round robin: after granting i, priority order becomes i+1..NUM_REQ-1,0..i (wrap at NUM_REQ-1 -> 0).
//    Pointer advances only on a grant; CLEAR does not move it.
//  - ReqData captured into LatchData at SETUP entry; later ReqData changes ignored for that write.
//  - Req dropped mid-transaction: write still completes and Ack still pulses. Req still high in cycle after Ack
//    is a new request and is arbitrated normally (requester now lowest priority).
//  - ClearReq arriving while Busy waits until IDLE; it then beats any pending Req. ClearReq must be held until ClearAck.
//  - Reset asserted in any state: next edge applies reset values; in-flight write abandoned, no Ack.
//  - LatchData outside SETUP/STROBE/HOLD keeps last written value (no glitching on the latch inputs).
// CONFIGURATION
//  - LATCH4_READBACK_EN defined: LatchQ port exists; in HOLD, LatchQ compared with LatchData; mismatch ->
//    WriteErr=1 for the cycle after HOLD. Ack still issued. After CLEAR, LatchQ!=0 also pulses WriteErr.
//  - Not defined: no LatchQ port, WriteErr constant 0, no compare logic.
// STRUCTURE
//  - Package latch4_ctrl_pkg: LATCH_W=4, enum typedef ctrl_state_t {IDLE,CLEAR,SETUP,STROBE,HOLD}.
//  - Sub-module rr_arbiter #(NUM_REQ): Req vector + advance strobe in, one-hot grant + index out, owns RR pointer.
//  - Top holds FSM, data capture, output registers, optional readback compare.
// TESTING
//  - Reset then Req=4'b0001, ReqData[3:0]=4'hA -> LatchGate high exactly cycle t+2, LatchData=4'hA t+1..t+3, Ack=4'b0001 at t+3.
//  - Req=4'b1111 held, data i=4'h1..4'h4 -> grant order 0,1,2,3,0; one Ack per 4 cycles; LatchData follows.
//  - ClearReq and Req[2] same cycle in IDLE -> CLEAR first (LatchReset=1, ClearAck=1), then write of requester 2.
//  - Req[1] dropped during STROBE -> Ack[1] still pulses in HOLD; no second write.
//  - Reset asserted during STROBE -> next cycle LatchGate=0, LatchEnable=0, Busy=0, no Ack; next grant goes to requester 0.
//  - LATCH4_READBACK_EN: model LatchQ stuck at 4'h0, write 4'h5 -> WriteErr=1 the cycle after HOLD; write 4'h0 -> no WriteErr.

Source files
------------

// File: rtl/latch4_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package  : latch4_ctrl_pkg                                                  |
// | Brief    : Shared width, controller state encoding and index-wrap helper.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package latch4_ctrl_pkg;

  localparam int LATCH_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4
  } ctrl_state_t;

  // Wraps an index that has been offset by at most n-1 back into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                       |
// | Brief    : Round-robin arbiter; the pointer names the highest-priority      |
// |            requester and moves past the winner on each advance strobe.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module rr_arbiter
  import latch4_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_advance,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;

  // Scan from the pointer upward, wrapping; first active request wins.
  always_comb begin
    w_cand  = '0;
    w_idx   = '0;
    w_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'(rr_wrap(int'(r_ptr) + k, NUM_REQ));
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        w_idx           = w_cand;
        w_grant[w_cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= IDX_W'(rr_wrap(int'(w_idx) + 1, NUM_REQ));
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/latch4_write_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : latch4_write_arbiter                                             |
// | Brief    : Shares a 4-bit gated D-latch among NUM_REQ writers using         |
// |            round-robin grant and a SETUP/STROBE/HOLD gate sequence, plus    |
// |            a clear command. Define LATCH4_READBACK_EN to add LatchQ         |
// |            readback checking on the WriteErr output.                        |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module latch4_write_arbiter
  import latch4_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [LATCH_W*NUM_REQ-1:0] ReqData,
  output logic [NUM_REQ-1:0]         Ack,
  input  logic                       ClearReq,
  output logic                       ClearAck,
  output logic [LATCH_W-1:0]         LatchData,
  output logic                       LatchEnable,
  output logic                       LatchReset,
  output logic                       LatchGate,
  output logic                       Busy,
  output logic [$clog2(NUM_REQ)-1:0] GrantId,
`ifdef LATCH4_READBACK_EN
  input  logic [LATCH_W-1:0]         LatchQ,
`endif
  output logic                       WriteErr
);

  localparam int IDX_W = $clog2(NUM_REQ);

  ctrl_state_t        r_state;
  ctrl_state_t        w_next;
  logic               w_advance;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [LATCH_W-1:0] w_wdata;

  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] r_grant_oh;
  logic [IDX_W-1:0]   r_grant_id;
  logic [LATCH_W-1:0] r_latch_data;
  logic               r_clear_ack;
  logic               r_latch_en;
  logic               r_latch_rst;
  logic               r_latch_gate;
  logic               r_busy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk         (Clock),
    .rst         (Reset),
    .i_req       (Req),
    .i_advance   (w_advance),
    .o_grant     (w_arb_grant),
    .o_grant_idx (w_arb_idx)
  );

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_idx == IDX_W'(i)) begin
        w_wdata = ReqData[i*LATCH_W +: LATCH_W];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Pending clears are only looked at from IDLE, where they beat any write request.
  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    case (r_state)
      IDLE: begin
        if (ClearReq) begin
          w_next = CLEAR;
        end else if (|Req) begin
          w_next    = SETUP;
          w_advance = 1'b1;
        end
      end
      CLEAR:   w_next = IDLE;
      SETUP:   w_next = STROBE;
      STROBE:  w_next = HOLD;
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a clean flop output.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ack        <= '0;
      r_grant_oh   <= '0;
      r_grant_id   <= '0;
      r_latch_data <= '0;
      r_clear_ack  <= 1'b0;
      r_latch_en   <= 1'b0;
      r_latch_rst  <= 1'b0;
      r_latch_gate <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_latch_en   <= 1'b1;
      r_busy       <= (w_next != IDLE);
      r_latch_gate <= (w_next == STROBE);
      r_latch_rst  <= (w_next == CLEAR);
      r_clear_ack  <= (w_next == CLEAR);
      r_ack        <= (w_next == HOLD) ? r_grant_oh : '0;
      if (w_advance) begin
        r_grant_id   <= w_arb_idx;
        r_grant_oh   <= w_arb_grant;
        r_latch_data <= w_wdata;
      end
    end
  end

  assign Ack         = r_ack;
  assign ClearAck    = r_clear_ack;
  assign LatchData   = r_latch_data;
  assign LatchEnable = r_latch_en;
  assign LatchReset  = r_latch_rst;
  assign LatchGate   = r_latch_gate;
  assign Busy        = r_busy;
  assign GrantId     = r_grant_id;

`ifdef LATCH4_READBACK_EN
  logic r_write_err;

  // HOLD checks the written value; CLEAR checks that the latch really reads zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_write_err <= 1'b0;
    end else begin
      r_write_err <= ((r_state == HOLD)  && (LatchQ != r_latch_data)) ||
                     ((r_state == CLEAR) && (LatchQ != '0));
    end
  end

  assign WriteErr = r_write_err;
`else
  assign WriteErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_latch4_write_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_latch4_write_arbiter                                          |
// | Brief    : Directed-vector bench for latch4_write_arbiter (NUM_REQ=4).      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_latch4_write_arbiter;

  logic        Clock;
  logic        Reset;
  logic [3:0]  Req;
  logic [15:0] ReqData;
  logic [3:0]  Ack;
  logic        ClearReq;
  logic        ClearAck;
  logic [3:0]  LatchData;
  logic        LatchEnable;
  logic        LatchReset;
  logic        LatchGate;
  logic        Busy;
  logic [1:0]  GrantId;
  logic        WriteErr;
`ifdef LATCH4_READBACK_EN
  logic [3:0]  LatchQ;
`endif

  int n_checks;
  int n_fail;

  latch4_write_arbiter #(
    .NUM_REQ (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Req         (Req),
    .ReqData     (ReqData),
    .Ack         (Ack),
    .ClearReq    (ClearReq),
    .ClearAck    (ClearAck),
    .LatchData   (LatchData),
    .LatchEnable (LatchEnable),
    .LatchReset  (LatchReset),
    .LatchGate   (LatchGate),
    .Busy        (Busy),
    .GrantId     (GrantId),
`ifdef LATCH4_READBACK_EN
    .LatchQ      (LatchQ),
`endif
    .WriteErr    (WriteErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] rdata;
    logic        clr;
    logic [3:0]  ack;
    logic        cack;
    logic [3:0]  data;
    logic        gate;
    logic        lrst;
    logic        busy;
    logic [1:0]  gid;
    logic        en;
  } vec_t;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  vec_t vt[12];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    Req      = '0;
    ReqData  = '0;
    ClearReq = 1'b0;
`ifdef LATCH4_READBACK_EN
    LatchQ   = 4'h0;
`endif

    //          rst  req      rdata     clr   ack      cack  data   gate  lrst  busy  gid    en
    vt[0]  = '{1'b1, 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[1]  = '{1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[2]  = '{1'b0, 4'b0001, 16'h000A, 1'b0, 4'b0000, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1};
    vt[3]  = '{1'b0, 4'b0001, 16'h000A, 1'b0, 4'b0000, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1};
    vt[4]  = '{1'b0, 4'b0001, 16'h000A, 1'b0, 4'b0001, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1};
    vt[5]  = '{1'b0, 4'b0000, 16'h000A, 1'b0, 4'b0000, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[6]  = '{1'b0, 4'b0100, 16'h0700, 1'b1, 4'b0000, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
    vt[7]  = '{1'b0, 4'b0100, 16'h0700, 1'b0, 4'b0000, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    vt[8]  = '{1'b0, 4'b0100, 16'h0700, 1'b0, 4'b0000, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
    vt[9]  = '{1'b0, 4'b0100, 16'h0F00, 1'b0, 4'b0000, 1'b0, 4'h7, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1};
    vt[10] = '{1'b0, 4'b0100, 16'h0F00, 1'b0, 4'b0100, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
    vt[11] = '{1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1};

    #2;
    for (int v = 0; v < 12; v++) begin
      Reset    = vt[v].rst;
      Req      = vt[v].req;
      ReqData  = vt[v].rdata;
      ClearReq = vt[v].clr;
      tick();
      check($sformatf("vec%0d {ack,cack,data,gate,lrst,busy,gid,en}", v),
            32'({Ack, ClearAck, LatchData, LatchGate, LatchReset, Busy, GrantId, LatchEnable}),
            32'({vt[v].ack, vt[v].cack, vt[v].data, vt[v].gate, vt[v].lrst, vt[v].busy,
                 vt[v].gid, vt[v].en}));
    end

    // All requesters held: grants rotate 0,1,2,3,0 with one Ack every 4 cycles.
    Reset = 1'b1;
    tick();
    Reset   = 1'b0;
    Req     = 4'b1111;
    ReqData = 16'h4321;
    for (int w = 0; w < 5; w++) begin
      tick();
      check($sformatf("rr%0d grant", w), 32'(GrantId), 32'(w % 4));
      check($sformatf("rr%0d data", w), 32'(LatchData), 32'((w % 4) + 1));
      tick();
      check($sformatf("rr%0d gate", w), 32'(LatchGate), 32'd1);
      tick();
      check($sformatf("rr%0d ack", w), 32'(Ack), 32'(4'b0001 << (w % 4)));
      tick();
      check($sformatf("rr%0d idle", w), 32'({Busy, Ack}), 32'd0);
    end

    // Request withdrawn during STROBE still completes exactly once.
    Reset = 1'b1;
    tick();
    Reset   = 1'b0;
    Req     = 4'b0010;
    ReqData = 16'h0050;
    tick();
    check("drop grant", 32'({GrantId, LatchData}), 32'({2'd1, 4'h5}));
    tick();
    Req = 4'b0000;
    tick();
    check("drop ack", 32'(Ack), 32'b0010);
    tick();
`ifndef LATCH4_READBACK_EN
    check("writeerr tied", 32'(WriteErr), 32'd0);
`endif
    check("drop idle1", 32'({Busy, Ack}), 32'd0);
    tick();
    check("drop idle2", 32'({Busy, Ack}), 32'd0);

    // Reset in STROBE abandons the write and restores requester 0 priority.
    Req     = 4'b0010;
    ReqData = 16'h0060;
    tick();
    check("rst grant", 32'(GrantId), 32'd1);
    tick();
    check("rst strobe", 32'(LatchGate), 32'd1);
    Reset = 1'b1;
    Req   = 4'b0000;
    tick();
    check("rst applied {gate,en,busy,ack}", 32'({LatchGate, LatchEnable, Busy, Ack}), 32'd0);
    Reset   = 1'b0;
    Req     = 4'b1111;
    ReqData = 16'h4321;
    tick();
    check("post-rst grant", 32'({Busy, GrantId, LatchData}), 32'({1'b1, 2'd0, 4'h1}));
    Req = 4'b0000;
    tick();
    tick();
    check("post-rst ack", 32'(Ack), 32'b0001);
    tick();

`ifdef LATCH4_READBACK_EN
    // Latch readback stuck at zero: 4'h5 mismatches, 4'h0 matches.
    Req     = 4'b0001;
    ReqData = 16'h0005;
    tick();
    tick();
    tick();
    Req = 4'b0000;
    tick();
    check("rb err on 5", 32'(WriteErr), 32'd1);
    tick();
    check("rb err clears", 32'(WriteErr), 32'd0);
    Req     = 4'b0001;
    ReqData = 16'h0000;
    tick();
    tick();
    tick();
    Req = 4'b0000;
    tick();
    check("rb no err on 0", 32'(WriteErr), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
